// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one valid/ready memory port between the picorv32
// native port and the vector coprocessor port. Round-robin on collisions,
// request latched and held until the memory completes, out-of-range accesses
// completed locally, saturating collision counter.
module mem_port_arbiter #(
    parameter int MEM_BYTES = 1024,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_mem_valid,
    input  logic             cpu_mem_instr,
    input  logic [31:0]      cpu_mem_addr,
    input  logic [31:0]      cpu_mem_wdata,
    input  logic [3:0]       cpu_mem_wstrb,
    output logic             cpu_mem_ready,
    output logic [31:0]      cpu_mem_rdata,
    input  logic             vec_mem_valid,
    input  logic [31:0]      vec_mem_addr,
    input  logic [31:0]      vec_mem_wdata,
    input  logic [3:0]       vec_mem_wstrb,
    output logic             vec_mem_ready,
    output logic [31:0]      vec_mem_rdata,
    output logic             mem_valid,
    output logic             mem_instr,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic             mem_ready,
    input  logic [31:0]      mem_rdata,
    output logic             grant_vec,
    output logic [CNT_W-1:0] conflict_cnt,
    output logic             oob
);

    typedef enum logic [1:0] {IDLE, CPU, VEC, ERR} state_t;

    localparam logic [31:0] ADDR_LIMIT = 32'(MEM_BYTES);

    state_t      state;
    state_t      state_nxt;
    logic        last_vec;      // 1 when the coprocessor held the most recent grant
    logic        req_any;
    logic        collide;
    logic        pick_vec;
    logic        pick_instr;
    logic        pick_oob;
    logic [31:0] pick_addr;
    logic [31:0] pick_wdata;
    logic [3:0]  pick_wstrb;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Choose the winner among the current requests; on a collision the side
    // that did not win last time gets the port.
    always_comb begin
        req_any    = cpu_mem_valid || vec_mem_valid;
        collide    = cpu_mem_valid && vec_mem_valid;
        pick_vec   = collide ? !last_vec : vec_mem_valid;
        pick_addr  = pick_vec ? vec_mem_addr  : cpu_mem_addr;
        pick_wdata = pick_vec ? vec_mem_wdata : cpu_mem_wdata;
        pick_wstrb = pick_vec ? vec_mem_wstrb : cpu_mem_wstrb;
        pick_instr = pick_vec ? 1'b0 : cpu_mem_instr;
        pick_oob   = pick_addr >= ADDR_LIMIT;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and requester-side handshake outputs.
    always_comb begin
        state_nxt     = state;
        cpu_mem_ready = 1'b0;
        cpu_mem_rdata = 32'h0;
        vec_mem_ready = 1'b0;
        vec_mem_rdata = 32'h0;
        grant_vec     = 1'b0;
        oob           = 1'b0;
        case (state)
            IDLE: begin
                if (req_any) begin
                    if (pick_oob)      state_nxt = ERR;
                    else if (pick_vec) state_nxt = VEC;
                    else               state_nxt = CPU;
                end
            end
            CPU: begin
                cpu_mem_ready = mem_ready;
                cpu_mem_rdata = mem_ready ? mem_rdata : 32'h0;
                if (mem_ready) state_nxt = IDLE;
            end
            VEC: begin
                grant_vec     = 1'b1;
                vec_mem_ready = mem_ready;
                vec_mem_rdata = mem_ready ? mem_rdata : 32'h0;
                if (mem_ready) state_nxt = IDLE;
            end
            ERR: begin
                // Out-of-range access finishes here with zero data; last_vec
                // still names the requester that was granted.
                oob           = 1'b1;
                grant_vec     = last_vec;
                cpu_mem_ready = !last_vec;
                vec_mem_ready = last_vec;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Downstream request registers, grant history and collision counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_valid    <= 1'b0;
            mem_instr    <= 1'b0;
            mem_addr     <= 32'h0;
            mem_wdata    <= 32'h0;
            mem_wstrb    <= 4'h0;
            last_vec     <= 1'b1;
            conflict_cnt <= '0;
        end else begin
            if (state == IDLE && req_any) begin
                mem_addr  <= pick_addr;
                mem_wdata <= pick_wdata;
                mem_wstrb <= pick_wstrb;
                mem_instr <= pick_instr;
                mem_valid <= !pick_oob;
                last_vec  <= pick_vec;
                if (collide) conflict_cnt <= sat_inc(conflict_cnt);
            end else if ((state == CPU || state == VEC) && mem_ready) begin
                mem_valid <= 1'b0;
                mem_wstrb <= 4'h0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter with a one-cycle
// memory model, a table of single-transaction vectors and hand sequences.
module tb_mem_port_arbiter;

    localparam int MEM_BYTES = 1024;
    localparam int CNT_W     = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             cpu_mem_valid, cpu_mem_instr;
    logic [31:0]      cpu_mem_addr, cpu_mem_wdata;
    logic [3:0]       cpu_mem_wstrb;
    logic             cpu_mem_ready;
    logic [31:0]      cpu_mem_rdata;
    logic             vec_mem_valid;
    logic [31:0]      vec_mem_addr, vec_mem_wdata;
    logic [3:0]       vec_mem_wstrb;
    logic             vec_mem_ready;
    logic [31:0]      vec_mem_rdata;
    logic             mem_valid, mem_instr;
    logic [31:0]      mem_addr, mem_wdata;
    logic [3:0]       mem_wstrb;
    logic             mem_ready;
    logic [31:0]      mem_rdata;
    logic             grant_vec;
    logic [CNT_W-1:0] conflict_cnt;
    logic             oob;

    mem_port_arbiter #(.MEM_BYTES(MEM_BYTES), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .cpu_mem_valid(cpu_mem_valid), .cpu_mem_instr(cpu_mem_instr),
        .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata),
        .cpu_mem_wstrb(cpu_mem_wstrb), .cpu_mem_ready(cpu_mem_ready),
        .cpu_mem_rdata(cpu_mem_rdata),
        .vec_mem_valid(vec_mem_valid), .vec_mem_addr(vec_mem_addr),
        .vec_mem_wdata(vec_mem_wdata), .vec_mem_wstrb(vec_mem_wstrb),
        .vec_mem_ready(vec_mem_ready), .vec_mem_rdata(vec_mem_rdata),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .grant_vec(grant_vec),
        .conflict_cnt(conflict_cnt), .oob(oob)
    );

    always #5 clk = ~clk;

    // One-cycle memory model: answers the cycle after mem_valid is seen.
    logic [31:0] mem [0:255];
    logic        stall;
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE0000 | 32'(i);
            mem[0]    <= 32'h00400113;
            mem_ready <= 1'b0;
            mem_rdata <= 32'h0;
        end else if (mem_valid && !mem_ready && !stall && mem_addr < 32'(MEM_BYTES)) begin
            mem_ready <= 1'b1;
            mem_rdata <= mem[mem_addr[9:2]];
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end else begin
            mem_ready <= 1'b0;
            mem_rdata <= 32'h0;
        end
    end

    int errs   = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Request streams for the engine below.
    logic [31:0] c_addr [8];
    logic [31:0] c_wdata [8];
    logic [3:0]  c_wstrb [8];
    logic        c_instr [8];
    logic [31:0] v_addr [8];
    logic [31:0] v_wdata [8];
    logic [3:0]  v_wstrb [8];
    logic [31:0] c_got [8];
    logic [31:0] v_got [8];
    int          order [16];
    int          ng;
    int          first_lat;
    logic        oob_seen, memv_seen;

    task automatic load_cpu(input int k);
        cpu_mem_valid = 1'b1;
        cpu_mem_addr  = c_addr[k];
        cpu_mem_wdata = c_wdata[k];
        cpu_mem_wstrb = c_wstrb[k];
        cpu_mem_instr = c_instr[k];
    endtask

    task automatic load_vec(input int k);
        vec_mem_valid = 1'b1;
        vec_mem_addr  = v_addr[k];
        vec_mem_wdata = v_wdata[k];
        vec_mem_wstrb = v_wstrb[k];
    endtask

    // Drive ncpu/nvec back-to-back requests (called at a negedge with the DUT
    // idle); each side issues its next request as soon as the previous one is ready.
    task automatic serve(input int ncpu, input int nvec, input string tag);
        int ci  = 0;
        int vi  = 0;
        int cyc = 0;
        ng = 0; first_lat = -1; oob_seen = 1'b0; memv_seen = 1'b0;
        if (ncpu > 0) load_cpu(0); else cpu_mem_valid = 1'b0;
        if (nvec > 0) load_vec(0); else vec_mem_valid = 1'b0;
        while ((ci < ncpu || vi < nvec) && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (oob) oob_seen = 1'b1;
            if (mem_valid) memv_seen = 1'b1;
            if (cpu_mem_ready) begin
                check({tag, " vec_ready_while_cpu"}, 32'(vec_mem_ready), 32'd0);
                check({tag, " grant_vec_cpu"}, 32'(grant_vec), 32'd0);
                check({tag, " mem_instr_cpu"}, 32'(mem_instr), 32'(c_instr[ci]));
                if (first_lat < 0) first_lat = cyc;
                c_got[ci] = cpu_mem_rdata;
                order[ng] = 0; ng++; ci++;
                if (ci < ncpu) load_cpu(ci); else cpu_mem_valid = 1'b0;
            end
            if (vec_mem_ready) begin
                check({tag, " grant_vec_vec"}, 32'(grant_vec), 32'd1);
                check({tag, " mem_instr_vec"}, 32'(mem_instr), 32'd0);
                if (first_lat < 0) first_lat = cyc;
                v_got[vi] = vec_mem_rdata;
                order[ng] = 1; ng++; vi++;
                if (vi < nvec) load_vec(vi); else vec_mem_valid = 1'b0;
            end
        end
        if (ci < ncpu || vi < nvec) begin
            checks++; errs++;
            $display("FAIL %s timeout: served cpu %0d vec %0d, required %0d/%0d", tag, ci, vi, ncpu, nvec);
            cpu_mem_valid = 1'b0;
            vec_mem_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic             cv;
        logic [31:0]      ca;
        logic [3:0]       cs;
        logic [31:0]      cd;
        logic             ci;
        logic             vv;
        logic [31:0]      va;
        logic [3:0]       vs;
        logic [31:0]      vd;
        int               first;   // 0 = cpu served first, 1 = vec
        int               lat;     // negedges from request to first ready
        logic [31:0]      crd;
        logic [31:0]      vrd;
        logic [CNT_W-1:0] cnt;
        logic             xoob;
        logic             memv;
    } vec_t;

    vec_t tbl [6];

    initial begin
        // Collision from reset, CPU fetch, second collision (vec's turn),
        // vec out-of-range write, cpu out-of-range read, last in-range word.
        tbl[0] = '{1'b1, 32'd4,    4'h0, 32'h0, 1'b0, 1'b1, 32'd400,  4'h0, 32'h0,
                   0, 2, 32'hC0DE0001, 32'hC0DE0064, 16'd1, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 32'd0,    4'h0, 32'h0, 1'b1, 1'b0, 32'd0,    4'h0, 32'h0,
                   0, 2, 32'h00400113, 32'h0, 16'd1, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 32'd8,    4'h0, 32'h0, 1'b0, 1'b1, 32'd12,   4'h0, 32'h0,
                   1, 2, 32'hC0DE0002, 32'hC0DE0003, 16'd2, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 32'd0,    4'h0, 32'h0, 1'b0, 1'b1, 32'd1024, 4'hF, 32'hFFFFFFFF,
                   1, 1, 32'h0, 32'h0, 16'd2, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 32'hFFFFFFFC, 4'h0, 32'h0, 1'b1, 1'b0, 32'd0, 4'h0, 32'h0,
                   0, 1, 32'h0, 32'h0, 16'd2, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 32'd1020, 4'h0, 32'h0, 1'b0, 1'b0, 32'd0,    4'h0, 32'h0,
                   0, 2, 32'hC0DE00FF, 32'h0, 16'd2, 1'b0, 1'b1};

        reset = 1'b1; stall = 1'b0;
        cpu_mem_valid = 0; cpu_mem_instr = 0; cpu_mem_addr = 0; cpu_mem_wdata = 0; cpu_mem_wstrb = 0;
        vec_mem_valid = 0; vec_mem_addr = 0; vec_mem_wdata = 0; vec_mem_wstrb = 0;
        repeat (3) @(negedge clk);
        check("rst mem_valid", 32'(mem_valid), 32'd0);
        check("rst mem_wstrb", 32'(mem_wstrb), 32'd0);
        check("rst grant_vec", 32'(grant_vec), 32'd0);
        check("rst conflict_cnt", 32'(conflict_cnt), 32'd0);
        check("rst oob", 32'(oob), 32'd0);
        check("rst cpu_ready", 32'(cpu_mem_ready), 32'd0);
        check("rst vec_ready", 32'(vec_mem_ready), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            c_addr[0] = tbl[i].ca; c_wdata[0] = tbl[i].cd; c_wstrb[0] = tbl[i].cs; c_instr[0] = tbl[i].ci;
            v_addr[0] = tbl[i].va; v_wdata[0] = tbl[i].vd; v_wstrb[0] = tbl[i].vs;
            serve(tbl[i].cv ? 1 : 0, tbl[i].vv ? 1 : 0, $sformatf("v%0d", i));
            check($sformatf("v%0d first", i), 32'(order[0]), 32'(tbl[i].first));
            check($sformatf("v%0d latency", i), 32'(first_lat), 32'(tbl[i].lat));
            if (tbl[i].cv) check($sformatf("v%0d cpu_rdata", i), c_got[0], tbl[i].crd);
            if (tbl[i].vv) check($sformatf("v%0d vec_rdata", i), v_got[0], tbl[i].vrd);
            check($sformatf("v%0d conflict_cnt", i), 32'(conflict_cnt), 32'(tbl[i].cnt));
            check($sformatf("v%0d oob_pulse", i), 32'(oob_seen), 32'(tbl[i].xoob));
            check($sformatf("v%0d mem_valid_seen", i), 32'(memv_seen), 32'(tbl[i].memv));
        end

        // Vec byte write: request held stable downstream, only byte 1 changes.
        vec_mem_valid = 1'b1; vec_mem_addr = 32'd800; vec_mem_wstrb = 4'b0010; vec_mem_wdata = 32'h0000AB00;
        @(negedge clk);
        check("bw mem_valid", 32'(mem_valid), 32'd1);
        check("bw mem_addr c1", mem_addr, 32'd800);
        check("bw mem_wstrb c1", 32'(mem_wstrb), 32'h2);
        check("bw mem_wdata c1", mem_wdata, 32'h0000AB00);
        check("bw vec_ready c1", 32'(vec_mem_ready), 32'd0);
        vec_mem_addr = 32'd4; vec_mem_wstrb = 4'hF;   // must be ignored while granted
        @(negedge clk);
        check("bw vec_ready c2", 32'(vec_mem_ready), 32'd1);
        check("bw mem_addr c2", mem_addr, 32'd800);
        check("bw mem_wstrb c2", 32'(mem_wstrb), 32'h2);
        vec_mem_valid = 1'b0;
        @(negedge clk);
        check("bw mem_valid after", 32'(mem_valid), 32'd0);
        check("bw mem_wstrb after", 32'(mem_wstrb), 32'd0);
        check("bw mem[200]", mem[200], 32'hC0DEABC8);
        check("bw mem[1] untouched", mem[1], 32'hC0DE0001);

        // Four colliding pairs with both sides re-requesting immediately.
        for (int k = 0; k < 4; k++) begin
            c_addr[k] = 32'(16 + 4*k); c_wdata[k] = 0; c_wstrb[k] = 0; c_instr[k] = 1'b0;
            v_addr[k] = 32'(32 + 4*k); v_wdata[k] = 0; v_wstrb[k] = 0;
        end
        serve(4, 4, "rr");
        for (int k = 0; k < 8; k++) check($sformatf("rr order%0d", k), 32'(order[k]), 32'(k % 2));
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rr cpu_rdata%0d", k), c_got[k], 32'hC0DE0004 + 32'(k));
            check($sformatf("rr vec_rdata%0d", k), v_got[k], 32'hC0DE0008 + 32'(k));
        end
        check("rr conflict_cnt", 32'(conflict_cnt), 32'd9);

        // Reset while the vec access is stalled at the memory.
        stall = 1'b1;
        vec_mem_valid = 1'b1; vec_mem_addr = 32'd400; vec_mem_wstrb = 4'h0;
        @(negedge clk);
        @(negedge clk);
        check("mr grant_vec before", 32'(grant_vec), 32'd1);
        check("mr mem_valid before", 32'(mem_valid), 32'd1);
        check("mr vec_ready stalled", 32'(vec_mem_ready), 32'd0);
        #2 reset = 1'b1;
        #1;
        check("mr mem_valid async", 32'(mem_valid), 32'd0);
        check("mr grant_vec async", 32'(grant_vec), 32'd0);
        check("mr conflict_cnt async", 32'(conflict_cnt), 32'd0);
        check("mr mem_addr async", mem_addr, 32'd0);
        vec_mem_valid = 1'b0; stall = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        c_addr[0] = 32'd4; c_wdata[0] = 0; c_wstrb[0] = 0; c_instr[0] = 1'b0;
        v_addr[0] = 32'd8; v_wdata[0] = 0; v_wstrb[0] = 0;
        serve(1, 1, "pr");
        check("pr first", 32'(order[0]), 32'd0);
        check("pr cpu_rdata", c_got[0], 32'hC0DE0001);
        check("pr vec_rdata", v_got[0], 32'hC0DE0002);
        check("pr conflict_cnt", 32'(conflict_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
